// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the instruction ROM write port.
//
// Accepts a byte stream over a valid/ready handshake. The stream format is:
//   - a 16-bit little-endian word count N;
//   - N little-endian 32-bit words;
//   - a trailing XOR checksum of all payload bytes.
// Each word is written to consecutive ROM addresses starting at 0. The CPU is held in
// reset until a load completes with a matching checksum.
//
// Ports:
//   clk         system clock, all state on posedge
//   reset_n     synchronous active-low reset
//   start       one-cycle pulse, begins a load from IDLE, DONE or ERR
//   byte_in     stream byte
//   byte_valid  byte_in valid
//   byte_ready  loader accepts byte_in this cycle
//   mem_wEn     ROM write enable (single-cycle pulse per word)
//   mem_addr    ROM word address
//   mem_dataIn  ROM write data
//   busy        load in progress
//   done        sticky, last load succeeded
//   error       sticky, last load failed
//   cpu_hold    holds the CPU in reset
module imem_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DEPTH         = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [15:0]              len_q, len_d;
  // One extra bit so the final increment can reach N == DEPTH without wrapping.
  logic [ADDRESS_WIDTH:0]   addr_q, addr_d;
  logic [7:0]               csum_q, csum_d;
  logic [1:0]               idx_q, idx_d;
  logic [23:0]              shift_q, shift_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     ready_q, ready_d;
  logic                     wen_q, wen_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     hold_q, hold_d;

  logic        xfer;
  logic [15:0] len_full;

  assign xfer     = byte_valid && ready_q;
  assign len_full = {byte_in, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          csum_d  = '0;
          idx_d   = '0;
          addr_d  = '0;
          state_d = StLen0;
        end
      end
      StLen0: begin
        if (xfer) begin
          len_d   = {8'h00, byte_in};
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > DEPTH) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: shift_d[7:0]   = byte_in;
            2'd1: shift_d[15:8]  = byte_in;
            2'd2: shift_d[23:16] = byte_in;
            2'd3: begin
              data_d  = {byte_in, shift_q};
              state_d = StWrite;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        // The write itself happens this cycle; advance the address for the next word.
        addr_d = addr_q + 1'b1;
        if (32'(addr_q) + 32'd1 == 32'(len_q)) begin
          state_d = StCheck;
        end else begin
          state_d = StData;
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (byte_in == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are decoded from the next state and registered, so they always
  // describe the state the loader is in during the cycle they are visible.
  always_comb begin
    ready_d = (state_d == StLen0) || (state_d == StLen1) ||
              (state_d == StData) || (state_d == StCheck);
    wen_d   = (state_d == StWrite);
    busy_d  = !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
    hold_d  = (state_d != StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  assign byte_ready = ready_q;
  assign mem_wEn    = wen_q;
  assign mem_addr   = addr_q[ADDRESS_WIDTH-1:0];
  assign mem_dataIn = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = hold_q;

endmodule
